// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: sequencer for the GPIO pad-configuration serial chain.
// Fetches one PAD_CTRL_BITS word per GPIO from a synchronous config store.
// It shifts the words down the chain, starting with the farthest block and
// sending each word MSB first, and then pulses serial_load.
// Optional feature: define GPIO_LOADER_BITBANG_EN to add bb_* inputs. These
// drive the chain directly while the sequencer is idle.
module gpio_serial_loader #(
    parameter int unsigned NUM_GPIO      = 19,
    parameter int unsigned PAD_CTRL_BITS = 13,
    parameter int unsigned CLK_DIV       = 2
) (
    input  logic                                           clk,
    input  logic                                           resetn,
    input  logic                                           start,
    input  logic                                           abort,
`ifdef GPIO_LOADER_BITBANG_EN
    input  logic                                           bb_en,
    input  logic                                           bb_clock,
    input  logic                                           bb_data,
    input  logic                                           bb_load,
`endif
    output logic                                           busy,
    output logic                                           done,
    output logic                                           aborted,
    output logic [((NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1)-1:0] cfg_addr,
    output logic                                           cfg_rd,
    input  logic [PAD_CTRL_BITS-1:0]                       cfg_data,
    output logic                                           serial_clock,
    output logic                                           serial_data,
    output logic                                           serial_load,
    output logic                                           serial_resetn
);

    localparam int unsigned AddrW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
    localparam int unsigned BitW  = $clog2(PAD_CTRL_BITS);
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [AddrW-1:0] LastGpio = AddrW'(NUM_GPIO - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(PAD_CTRL_BITS - 1);
    localparam logic [DivW-1:0]  LastDiv  = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapt,
        StShiftLo,
        StShiftHi,
        StLoadHi,
        StLoadLo
    } state_e;

    state_e                   state_q, state_d;
    logic [AddrW-1:0]         cfg_addr_q, cfg_addr_d;  // doubles as the GPIO index
    logic [BitW-1:0]          bit_idx_q, bit_idx_d;
    logic [DivW-1:0]          div_cnt_q, div_cnt_d;
    logic [PAD_CTRL_BITS-1:0] word_q, word_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic                     cfg_rd_q, cfg_rd_d;
    logic                     sclk_q, sclk_d;
    logic                     sdata_q, sdata_d;
    logic                     sload_q, sload_d;

    logic phase_done;
    logic bb_active;
    logic start_ok;

    assign phase_done = (div_cnt_q == LastDiv);

`ifdef GPIO_LOADER_BITBANG_EN
    assign bb_active = bb_en;
`else
    assign bb_active = 1'b0;
`endif

    assign start_ok = start && !bb_active;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        cfg_addr_d = cfg_addr_q;
        bit_idx_d  = bit_idx_q;
        div_cnt_d  = '0;
        word_d     = word_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        cfg_rd_d   = 1'b0;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;
        sload_d    = sload_q;

        if (state_q != StIdle && abort) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
            sclk_d    = 1'b0;
            sdata_d   = 1'b0;
            sload_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef GPIO_LOADER_BITBANG_EN
                    sclk_d  = bb_en & bb_clock;
                    sdata_d = bb_en & bb_data;
                    sload_d = bb_en & bb_load;
`endif
                    if (start_ok) begin
                        state_d    = StFetch;
                        busy_d     = 1'b1;
                        cfg_addr_d = LastGpio;
                        cfg_rd_d   = 1'b1;
                        sclk_d     = 1'b0;
                        sdata_d    = 1'b0;
                        sload_d    = 1'b0;
                    end
                end
                StFetch: begin
                    state_d = StCapt;
                end
                StCapt: begin
                    // Store data is valid now; drive its MSB directly as the word buffer fills.
                    state_d   = StShiftLo;
                    word_d    = cfg_data;
                    bit_idx_d = LastBit;
                    sdata_d   = cfg_data[PAD_CTRL_BITS-1];
                end
                StShiftLo: begin
                    if (phase_done) begin
                        state_d = StShiftHi;
                        sclk_d  = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                StShiftHi: begin
                    if (phase_done) begin
                        sclk_d = 1'b0;
                        if (bit_idx_q != '0) begin
                            state_d   = StShiftLo;
                            bit_idx_d = bit_idx_q - 1'b1;
                            sdata_d   = word_q[bit_idx_d];
                        end else if (cfg_addr_q != '0) begin
                            state_d    = StFetch;
                            cfg_addr_d = cfg_addr_q - 1'b1;
                            cfg_rd_d   = 1'b1;
                        end else begin
                            state_d = StLoadHi;
                            sdata_d = 1'b0;
                            sload_d = 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                StLoadHi: begin
                    if (phase_done) begin
                        state_d = StLoadLo;
                        sload_d = 1'b0;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                StLoadLo: begin
                    if (phase_done) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    sclk_d  = 1'b0;
                    sdata_d = 1'b0;
                    sload_d = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cfg_addr_q <= '0;
            bit_idx_q  <= '0;
            div_cnt_q  <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            cfg_rd_q   <= 1'b0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            sload_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_addr_q <= cfg_addr_d;
            bit_idx_q  <= bit_idx_d;
            div_cnt_q  <= div_cnt_d;
            word_q     <= word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            cfg_rd_q   <= cfg_rd_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            sload_q    <= sload_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign cfg_addr      = cfg_addr_q;
    assign cfg_rd        = cfg_rd_q;
    assign serial_clock  = sclk_q;
    assign serial_data   = sdata_q;
    assign serial_load   = sload_q;
    assign serial_resetn = resetn;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: a two-block chain with a single clock phase per state.
// When GPIO_LOADER_BITBANG_EN is defined, the bench also exercises the bit-bang path.
module tb_gpio_serial_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [0:0]  cfg_addr;
    logic        cfg_rd;
    logic [12:0] cfg_data = '0;
    logic        serial_clock;
    logic        serial_data;
    logic        serial_load;
    logic        serial_resetn;
`ifdef GPIO_LOADER_BITBANG_EN
    logic        bb_en = 1'b0;
    logic        bb_clock = 1'b0;
    logic        bb_data = 1'b0;
    logic        bb_load = 1'b0;
`endif

    gpio_serial_loader #(
        .NUM_GPIO     (2),
        .PAD_CTRL_BITS(13),
        .CLK_DIV      (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
`ifdef GPIO_LOADER_BITBANG_EN
        .bb_en        (bb_en),
        .bb_clock     (bb_clock),
        .bb_data      (bb_data),
        .bb_load      (bb_load),
`endif
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .cfg_addr     (cfg_addr),
        .cfg_rd       (cfg_rd),
        .cfg_data     (cfg_data),
        .serial_clock (serial_clock),
        .serial_data  (serial_data),
        .serial_load  (serial_load),
        .serial_resetn(serial_resetn)
    );

    always #5 clk = ~clk;

    // Synchronous config store: data appears the cycle after the read strobe.
    logic [12:0] mem [2];
    always @(posedge clk) if (cfg_rd) cfg_data <= mem[cfg_addr];

    // Chain model and event counters, sampled away from the active edge.
    int          rise_cnt = 0, load_cnt = 0, busy_cyc = 0, done_cnt = 0, abort_cnt = 0;
    int          overlap_cnt = 0, dchg_cnt = 0;
    logic        prev_sclk = 1'b0, prev_sload = 1'b0, prev_sdata = 1'b0;
    logic [31:0] bits = '0;
    logic [12:0] sr0 = '0, sr1 = '0, latch0 = '0, latch1 = '0;

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        if (serial_clock && serial_load) overlap_cnt++;
        if (serial_clock && (serial_data != prev_sdata)) dchg_cnt++;
        if (serial_clock && !prev_sclk) begin
            rise_cnt++;
            bits = {bits[30:0], serial_data};
            sr1  = {sr1[11:0], sr0[12]};
            sr0  = {sr0[11:0], serial_data};
        end
        if (serial_load && !prev_sload) begin
            load_cnt++;
            latch0 = sr0;
            latch1 = sr1;
        end
        prev_sclk  = serial_clock;
        prev_sload = serial_load;
        prev_sdata = serial_data;
    end

    int n_checks = 0;
    int n_errs   = 0;
    int b_rise, b_load, b_busy, b_done, b_abort;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rise  = rise_cnt;
        b_load  = load_cnt;
        b_busy  = busy_cyc;
        b_done  = done_cnt;
        b_abort = abort_cnt;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mem[0] = 13'h0000;
        mem[1] = 13'h1FFF;
        repeat (3) @(negedge clk);
        check("rst_outputs", {24'b0, busy, done, aborted, cfg_rd, serial_clock, serial_data,
                              serial_load, cfg_addr}, 32'd0);
        check("rst_chain_resetn", {31'b0, serial_resetn}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("chain_resetn_follow", {31'b0, serial_resetn}, 32'd1);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // 1: all-ones word to the far block, then all zeros.
        snap();
        pulse_start();
        check("busy_after_start", {31'b0, busy}, 32'd1);
        wait_done(200);
        check("t1_rises", rise_cnt - b_rise, 32'd26);
        check("t1_bits", {6'b0, bits[25:0]}, 32'h03FF_E000);
        check("t1_loads", load_cnt - b_load, 32'd1);
        check("t1_busy_cycles", busy_cyc - b_busy, 32'd58);
        check("t1_done_count", done_cnt - b_done, 32'd1);
        check("t1_data_idle", {31'b0, serial_data}, 32'd0);
        check("t1_cfg_addr_hold", {31'b0, cfg_addr}, 32'd0);

        // 2: latched block fields after a load.
        mem[1] = 13'h1803;
        mem[0] = 13'h0403;
        pulse_start();
        wait_done(200);
        check("t2_far_word", {19'b0, latch1}, 32'h1803);
        check("t2_near_word", {19'b0, latch0}, 32'h0403);
        check("t2_far_ena_oeb_dm", {27'b0, latch1[12:10], latch1[1], latch1[0]}, 32'b11011);
        check("t2_near_ena_oeb_dm", {27'b0, latch0[12:10], latch0[1], latch0[0]}, 32'b00111);

        // 3: abort while bit 7 of the first word is on the chain.
        mem[1] = 13'h0AAA;
        snap();
        pulse_start();
        for (int n = 0; n < 100 && (rise_cnt - b_rise) < 6; n++) @(negedge clk);
        check("t3_reached_bit7", rise_cnt - b_rise, 32'd6);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t3_sclk_low", {31'b0, serial_clock}, 32'd0);
        check("t3_aborted", {31'b0, aborted}, 32'd1);
        check("t3_busy_low", {31'b0, busy}, 32'd0);
        check("t3_data_load_rd", {29'b0, serial_data, serial_load, cfg_rd}, 32'd0);
        repeat (10) @(negedge clk);
        check("t3_no_load", load_cnt - b_load, 32'd0);
        check("t3_no_done", done_cnt - b_done, 32'd0);
        check("t3_abort_once", abort_cnt - b_abort, 32'd1);
        check("t3_latch_kept", {6'b0, latch1, latch0}, {6'b0, 13'h1803, 13'h0403});
        mem[1] = 13'h1234;
        mem[0] = 13'h0567;
        pulse_start();
        wait_done(200);
        check("t3_restart_words", {6'b0, latch1, latch0}, {6'b0, 13'h1234, 13'h0567});

        // 4: start pulses mid-transfer are ignored, not queued.
        snap();
        pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(200);
        repeat (5) @(negedge clk);
        check("t4_one_done", done_cnt - b_done, 32'd1);
        check("t4_busy_cycles", busy_cyc - b_busy, 32'd58);
        check("t4_no_requeue", {31'b0, busy}, 32'd0);
        // start and abort together in IDLE: start wins.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("t4_start_wins", {31'b0, busy}, 32'd1);
        check("t4_no_aborted", {31'b0, aborted}, 32'd0);
        wait_done(200);

        // 5: asynchronous reset while the shift clock is high.
        pulse_start();
        repeat (8) @(negedge clk);
        for (int n = 0; n < 10 && !serial_clock; n++) @(negedge clk);
        check("t5_in_shift_hi", {31'b0, serial_clock}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t5_async_clear", {29'b0, serial_clock, serial_load, busy}, 32'd0);
        check("t5_chain_reset", {31'b0, serial_resetn}, 32'd0);
        @(negedge clk) resetn = 1'b1;
        mem[1] = 13'h0F0F;
        mem[0] = 13'h10F0;
        snap();
        pulse_start();
        wait_done(200);
        check("t5_restart_words", {6'b0, latch1, latch0}, {6'b0, 13'h0F0F, 13'h10F0});
        check("t5_busy_cycles", busy_cyc - b_busy, 32'd58);

`ifdef GPIO_LOADER_BITBANG_EN
        // 6: bit-bang passthrough while idle.
        @(negedge clk) begin bb_en = 1'b1; bb_clock = 1'b1; end
        @(negedge clk);
        check("t6_bb_clock_hi", {31'b0, serial_clock}, 32'd1);
        bb_clock = 1'b0;
        @(negedge clk);
        check("t6_bb_clock_lo", {31'b0, serial_clock}, 32'd0);
        pulse_start();
        repeat (2) @(negedge clk);
        check("t6_start_blocked", {31'b0, busy}, 32'd0);
        bb_en = 1'b0;
`endif

        check("no_clock_load_overlap", overlap_cnt, 32'd0);
        check("data_stable_when_high", dchg_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
